// File: rtl/reg_access_ctrl_if.sv
// Command/response bus between a requester and reg_access_ctrl.
// The master drives commands and accepts responses; the slave is the controller.
interface reg_access_ctrl_if #(
  parameter int unsigned DATA_W = 16
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic [1:0]        cmd_op;
  logic [3:0]        cmd_addr;
  logic [DATA_W-1:0] cmd_data;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_data;
  logic [3:0]        rsp_addr;
  logic              rsp_err;
  logic              rsp_last;

  modport master (
    output cmd_valid, cmd_op, cmd_addr, cmd_data, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_data, rsp_addr, rsp_err, rsp_last
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_addr, cmd_data, rsp_ready,
    output cmd_ready, rsp_valid, rsp_data, rsp_addr, rsp_err, rsp_last
  );
endinterface

// File: rtl/reg_access_ctrl.sv
// Register-bank access controller: read, write and full-bank dump commands.
// Define REG_ACC_ADDR_CHECK_EN to reject read/write addresses >= NUM_REGS early.
module reg_access_ctrl #(
  parameter int unsigned NUM_REGS = 14,
  parameter int unsigned DATA_W   = 16
) (
  input  logic              clk,
  input  logic              rst,
  reg_access_ctrl_if.slave  bus,
  output logic              rf_we,
  output logic [3:0]        rf_addr_wr,
  output logic [DATA_W-1:0] rf_data_wr,
  output logic [3:0]        rf_addr_rd1,
  output logic [3:0]        rf_addr_rd2,
  input  logic [DATA_W-1:0] rf_data_rd1,
  input  logic [DATA_W-1:0] rf_data_rd2
);

  typedef enum logic [2:0] {
    IDLE, WRITE, READ, DUMP_RD, DUMP_TX0, DUMP_TX1, RESP
  } state_t;

  localparam logic [3:0] LAST_IDX = 4'(NUM_REGS - 1);

  state_t            state_q, state_d;
  logic [3:0]        addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [DATA_W-1:0] rd2_q, rd2_d;
  logic [3:0]        idx_q, idx_d;
  logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
  logic [3:0]        rsp_addr_q, rsp_addr_d;
  logic              rsp_err_q, rsp_err_d;
  logic              rsp_last_q, rsp_last_d;

  assign bus.rsp_data = rsp_data_q;
  assign bus.rsp_addr = rsp_addr_q;
  assign bus.rsp_err  = rsp_err_q;
  assign bus.rsp_last = rsp_last_q;

  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    data_d        = data_q;
    rd2_d         = rd2_q;
    idx_d         = idx_q;
    rsp_data_d    = rsp_data_q;
    rsp_addr_d    = rsp_addr_q;
    rsp_err_d     = rsp_err_q;
    rsp_last_d    = rsp_last_q;
    bus.cmd_ready = 1'b0;
    bus.rsp_valid = 1'b0;
    rf_we         = 1'b0;
    rf_addr_wr    = '0;
    rf_data_wr    = '0;
    rf_addr_rd1   = '0;
    rf_addr_rd2   = '0;

    case (state_q)
      IDLE: begin
        bus.cmd_ready = !rst;
        if (bus.cmd_valid) begin
          addr_d = bus.cmd_addr;
          data_d = bus.cmd_data;
          case (bus.cmd_op)
            2'b00: state_d = READ;
            2'b01: state_d = WRITE;
            2'b10: begin
              idx_d   = '0;
              state_d = DUMP_RD;
            end
            default: begin
              rsp_data_d = '0;
              rsp_addr_d = bus.cmd_addr;
              rsp_err_d  = 1'b1;
              rsp_last_d = 1'b1;
              state_d    = RESP;
            end
          endcase
`ifdef REG_ACC_ADDR_CHECK_EN
          if ((bus.cmd_op == 2'b00 || bus.cmd_op == 2'b01) &&
              32'(bus.cmd_addr) >= NUM_REGS) begin
            rsp_data_d = '0;
            rsp_addr_d = bus.cmd_addr;
            rsp_err_d  = 1'b1;
            rsp_last_d = 1'b1;
            state_d    = RESP;
          end
`endif
        end
      end
      WRITE: begin
        // Gated by rst so a reset landing on this cycle aborts the write.
        rf_we      = !rst;
        rf_addr_wr = addr_q;
        rf_data_wr = data_q;
        rsp_data_d = data_q;
        rsp_addr_d = addr_q;
        rsp_err_d  = 1'b0;
        rsp_last_d = 1'b1;
        state_d    = RESP;
      end
      READ: begin
        rf_addr_rd1 = addr_q;
        rsp_data_d  = rf_data_rd1;
        rsp_addr_d  = addr_q;
        rsp_err_d   = 1'b0;
        rsp_last_d  = 1'b1;
        state_d     = RESP;
      end
      DUMP_RD: begin
        rf_addr_rd1 = idx_q;
        rf_addr_rd2 = idx_q + 4'd1;
        rsp_data_d  = rf_data_rd1;
        rsp_addr_d  = idx_q;
        rsp_err_d   = 1'b0;
        rsp_last_d  = (idx_q == LAST_IDX);
        rd2_d       = rf_data_rd2;
        state_d     = DUMP_TX0;
      end
      DUMP_TX0: begin
        bus.rsp_valid = 1'b1;
        if (bus.rsp_ready) begin
          // An odd bank ends on the rd1 half of the final pair.
          if (rsp_last_q) begin
            state_d = IDLE;
          end else begin
            rsp_data_d = rd2_q;
            rsp_addr_d = idx_q + 4'd1;
            rsp_last_d = ((idx_q + 4'd1) == LAST_IDX);
            state_d    = DUMP_TX1;
          end
        end
      end
      DUMP_TX1: begin
        bus.rsp_valid = 1'b1;
        if (bus.rsp_ready) begin
          if (rsp_last_q) begin
            state_d = IDLE;
          end else begin
            idx_d   = idx_q + 4'd2;
            state_d = DUMP_RD;
          end
        end
      end
      RESP: begin
        bus.rsp_valid = 1'b1;
        if (bus.rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      data_q     <= '0;
      rd2_q      <= '0;
      idx_q      <= '0;
      rsp_data_q <= '0;
      rsp_addr_q <= '0;
      rsp_err_q  <= 1'b0;
      rsp_last_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      rd2_q      <= rd2_d;
      idx_q      <= idx_d;
      rsp_data_q <= rsp_data_d;
      rsp_addr_q <= rsp_addr_d;
      rsp_err_q  <= rsp_err_d;
      rsp_last_q <= rsp_last_d;
    end
  end

endmodule
